dfp_normalize96: RTL and testbench
==================================

DFP_NORMALIZE96 -- requirements
Module: dfp_normalize96

Interface
REQ-001 The block SHALL have parameter N, default 25, giving the number of significand BCD digits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state SHALL change only on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have input ce, 1 bit, a clock enable; when low, all registers SHALL hold.
REQ-005 The block SHALL have input ld, 1 bit, a start strobe.
REQ-006 The block SHALL have input i, type DFP96UNX, the unnormalised value: nan, qnan, snan, infinity, sign, exp[11:0], and sig[(N+3)*4-1:0]; sig digits from the top are overflow digit, N significand digits, round digit, sticky digit.
REQ-007 The block SHALL have output o, type DFP96UN, the normalised value with sig[(N+1)*4-1:0], laid out as N digits followed by the round digit, for the rounding stage.
REQ-008 The block SHALL have output done, 1 bit, a one-cycle pulse marking o valid.
REQ-009 The block SHALL have output busy, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 States SHALL be IDLE, RSHIFT, LSHIFT and FIN.
REQ-011 In IDLE with ce&ld, the block SHALL capture i into working regs (ws, wx, wsig, wstk = sticky digit!=0) and branch:
- nan|infinity -> FIN;
- overflow digit !=0 -> RSHIFT;
- otherwise -> LSHIFT.
REQ-012 ld SHALL be ignored outside IDLE.
REQ-013 RSHIFT (one cycle):
- wsig shifts right one digit;
- the discarded digit is ORed into wstk;
- wx increments;
- if wx+1 == 12'hBFF, the result SHALL become infinity with sig zero;
- next state FIN.
REQ-014 LSHIFT: while MSD==0, wsig!=0 and wx!=0, wsig SHALL shift left one digit per cycle (zero digit in at the bottom) and wx SHALL decrement; otherwise next state FIN.
REQ-015 A zero significand SHALL keep its exponent and sign unchanged and take no shifts.
REQ-016 wx==0 with MSD==0 SHALL stop shifting and emit a denormal.
REQ-017 FIN SHALL drive o, pulse done for exactly one ce cycle and return to IDLE; o SHALL hold until the next FIN.
REQ-018 The sticky fold into the output round digit rd SHALL be:
- if wstk and rd==0, rd=1;
- if wstk and rd==5, rd=6;
- otherwise rd unchanged.
REQ-019 Latency SHALL be: ld edge t, done at edge t+1+s, where s is the number of shift cycles (0..N+1); NaN/inf s=0.
REQ-020 NaN and infinity flags, sign and sig SHALL pass through unmodified, with rd unfolded.

Reset
REQ-021 On rst, state SHALL be IDLE and done=0, busy=0, and o all-zero; rst SHALL take priority over ce and ld.
REQ-022 rst asserted mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-023 With DFPNORM_FAST_LZ_EN defined, LSHIFT SHALL perform the whole left shift in one cycle by min(leading-zero-digit count, wx) digits, so s<=1 on the left path.
REQ-024 Without DFPNORM_FAST_LZ_EN, the left shift SHALL be one digit per cycle per REQ-014.
REQ-025 Final o SHALL be identical in both builds; only latency differs.

Structure
REQ-026 The typedef DFP96UNX, the constant DFP_EXP_INF = 12'hBFF and the digit-count constants SHALL live in DFPPkg.
REQ-027 The fast path SHALL use one sub-module, dfp_lzd_digits, a combinational leading-zero BCD-digit counter parameterised by digit count.

Verification
REQ-028 The bench SHALL check the overflow case: overflow digit 1, exp 12'h300, rest 0 -> one RSHIFT, o.exp 12'h301, MSD 1, done at t+2.
REQ-029 The bench SHALL check the left-shift case: sig with 3 leading zero digits then 7, exp 12'h300 -> o.exp 12'h2FD, MSD 7, done at t+4 (t+2 in the fast build).
REQ-030 The bench SHALL check the denormal case: 5 leading zeros, exp 12'h002 -> 2 shifts, o.exp 0, 3 leading zeros remain.
REQ-031 The bench SHALL check the sticky fold: round digit 5, sticky digit 3 -> output rd 6; round digit 0, sticky digit 0 -> rd 0.
REQ-032 The bench SHALL check overflow to infinity: exp 12'hBFE with overflow digit set -> o.infinity=1, sig 0, exp 12'hBFF.
REQ-033 The bench SHALL check control behaviour:
- ld pulsed while busy is ignored;
- rst during LSHIFT -> IDLE next edge, no done;
- a NaN input -> done at t+1 with flags intact.

Source files
------------

// File: rtl/dfp_normalize96_pkg.sv
// Shared types and constants for the 96-bit decimal floating-point normaliser.
package DFPPkg;

    localparam int unsigned DFP_N      = 25;
    localparam int unsigned DFP_EXP_W  = 12;
    localparam int unsigned DFP_XSIG_W = (DFP_N + 3) * 4;
    localparam int unsigned DFP_OSIG_W = (DFP_N + 1) * 4;

    localparam logic [DFP_EXP_W-1:0] DFP_EXP_INF = 12'hBFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RSHIFT,
        ST_LSHIFT,
        ST_FIN
    } dfpnorm_state_e;

    // Unnormalised value: overflow digit, N digits, round digit, sticky digit.
    typedef struct packed {
        logic                  nan;
        logic                  qnan;
        logic                  snan;
        logic                  infinity;
        logic                  sign;
        logic [DFP_EXP_W-1:0]  exp;
        logic [DFP_XSIG_W-1:0] sig;
    } DFP96UNX;

    // Normalised value: N digits followed by the round digit.
    typedef struct packed {
        logic                  nan;
        logic                  qnan;
        logic                  snan;
        logic                  infinity;
        logic                  sign;
        logic [DFP_EXP_W-1:0]  exp;
        logic [DFP_OSIG_W-1:0] sig;
    } DFP96UN;

    // Fold the sticky flag into the round digit so 0 and 5 are never ambiguous.
    function automatic logic [3:0] fold_sticky(input logic [3:0] rd, input logic stk);
        if (stk && rd == 4'd0) return 4'd1;
        if (stk && rd == 4'd5) return 4'd6;
        return rd;
    endfunction

endpackage

// File: rtl/dfp_normalize96_lzd.sv
// Combinational leading-zero counter over D BCD digits (D when all zero).
module dfp_lzd_digits #(
    parameter int unsigned D = 26
) (
    input  logic [D*4-1:0]         digits,
    output logic [$clog2(D+1)-1:0] lz_c
);

    localparam int unsigned CW = $clog2(D + 1);

    // Scan from the most significant digit; first non-zero digit fixes the count.
    always_comb begin
        logic found;
        lz_c  = CW'(D);
        found = 1'b0;
        for (int k = int'(D) - 1; k >= 0; k--) begin
            if (!found && digits[k*4 +: 4] != 4'd0) begin
                lz_c  = CW'(int'(D) - 1 - k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dfp_normalize96.sv
// Decimal FP normaliser: one right shift on overflow, otherwise left shift
// until the MSD is non-zero or the exponent bottoms out (denormal).
// Build option DFPNORM_FAST_LZ_EN: do the whole left shift in a single cycle.
module dfp_normalize96
    import DFPPkg::*;
#(
    parameter int unsigned N = DFP_N
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    ce,
    input  logic    ld,
    input  DFP96UNX i,
    output DFP96UN  o,
    output logic    done,
    output logic    busy
);

    localparam int unsigned WD  = N + 2;          // overflow + N + round digits
    localparam int unsigned WW  = WD * 4;
    localparam int unsigned LD  = N + 1;          // N + round digits
    localparam int unsigned LZW = $clog2(LD + 1);

    dfpnorm_state_e state_q, state_d;
    logic                 ws_q,   ws_d;
    logic [DFP_EXP_W-1:0] wx_q,   wx_d;
    logic [WW-1:0]        wsig_q, wsig_d;
    logic                 wstk_q, wstk_d;
    logic                 wnan_q, wnan_d;
    logic                 wqnan_q, wqnan_d;
    logic                 wsnan_q, wsnan_d;
    logic                 winf_q, winf_d;
    DFP96UN               o_q,    o_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [LD*4-1:0] lzd_in_c;
    logic [LZW-1:0]  lz_c;
    logic            nonzero_c;
    logic            msd_zero_c;
    logic [3:0]      rd_c;

    // The counter looks at the incoming value while idle, else the working value.
    assign lzd_in_c   = (state_q == ST_IDLE) ? i.sig[(N+2)*4-1:4] : wsig_q[LD*4-1:0];
    assign nonzero_c  = (lz_c != LZW'(LD));
    assign msd_zero_c = (lz_c != '0);

    dfp_lzd_digits #(.D(LD)) u_lzd (
        .digits (lzd_in_c),
        .lz_c   (lz_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        wx_d    = wx_q;
        wsig_d  = wsig_q;
        wstk_d  = wstk_q;
        wnan_d  = wnan_q;
        wqnan_d = wqnan_q;
        wsnan_d = wsnan_q;
        winf_d  = winf_q;
        o_d     = o_q;
        done_d  = done_q;
        rd_c    = (wnan_q || winf_q) ? wsig_q[3:0] : fold_sticky(wsig_q[3:0], wstk_q);
`ifdef DFPNORM_FAST_LZ_EN
        begin : fast_amt
            logic [DFP_EXP_W-1:0] amt;
            amt = (DFP_EXP_W'(lz_c) < wx_q) ? DFP_EXP_W'(lz_c) : wx_q;
`endif
        if (ce) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ld) begin
                        ws_d    = i.sign;
                        wx_d    = i.exp;
                        wsig_d  = i.sig[DFP_XSIG_W-1:4];
                        wstk_d  = (i.sig[3:0] != 4'd0);
                        wnan_d  = i.nan;
                        wqnan_d = i.qnan;
                        wsnan_d = i.snan;
                        winf_d  = i.infinity;
                        if (i.nan || i.infinity)
                            state_d = ST_FIN;
                        else if (i.sig[DFP_XSIG_W-1 -: 4] != 4'd0)
                            state_d = ST_RSHIFT;
                        else if (msd_zero_c && nonzero_c && i.exp != '0)
                            state_d = ST_LSHIFT;
                        else
                            state_d = ST_FIN;
                    end
                end
                ST_RSHIFT: begin
                    wsig_d  = wsig_q >> 4;
                    wstk_d  = wstk_q | (wsig_q[3:0] != 4'd0);
                    wx_d    = wx_q + DFP_EXP_W'(1);
                    if (wx_q + DFP_EXP_W'(1) == DFP_EXP_INF) begin
                        winf_d = 1'b1;
                        wsig_d = '0;
                        wstk_d = 1'b0;
                    end
                    state_d = ST_FIN;
                end
                ST_LSHIFT: begin
`ifdef DFPNORM_FAST_LZ_EN
                    wsig_d  = wsig_q << {amt, 2'b00};
                    wx_d    = wx_q - amt;
                    state_d = ST_FIN;
`else
                    wsig_d  = wsig_q << 4;
                    wx_d    = wx_q - DFP_EXP_W'(1);
                    // Decide on the post-shift value so the last shift goes straight to FIN.
                    state_d = (lz_c >= LZW'(2) && nonzero_c && wx_q != DFP_EXP_W'(1))
                              ? ST_LSHIFT : ST_FIN;
`endif
                end
                ST_FIN: begin
                    o_d.nan      = wnan_q;
                    o_d.qnan     = wqnan_q;
                    o_d.snan     = wsnan_q;
                    o_d.infinity = winf_q;
                    o_d.sign     = ws_q;
                    o_d.exp      = wx_q;
                    o_d.sig      = {wsig_q[LD*4-1:4], rd_c};
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef DFPNORM_FAST_LZ_EN
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ws_q    <= 1'b0;
            wx_q    <= '0;
            wsig_q  <= '0;
            wstk_q  <= 1'b0;
            wnan_q  <= 1'b0;
            wqnan_q <= 1'b0;
            wsnan_q <= 1'b0;
            winf_q  <= 1'b0;
            o_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            wx_q    <= wx_d;
            wsig_q  <= wsig_d;
            wstk_q  <= wstk_d;
            wnan_q  <= wnan_d;
            wqnan_q <= wqnan_d;
            wsnan_q <= wsnan_d;
            winf_q  <= winf_d;
            o_q     <= o_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o    = o_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dfp_normalize96.sv
// Self-checking bench for dfp_normalize96 against a digit-array reference model.
module tb_dfp_normalize96;
    import DFPPkg::*;

    localparam int unsigned NN = DFP_N;

    logic    clk = 1'b0;
    logic    rst, ce, ld;
    DFP96UNX din;
    DFP96UN  o;
    logic    done, busy;

    int n_vec = 0;
    int n_bad = 0;

    dfp_normalize96 #(.N(NN)) dut (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .ld   (ld),
        .i    (din),
        .o    (o),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: works on a plain digit list, index 0 = overflow digit.
    task automatic model(input DFP96UNX x, output DFP96UN eo, output int lat);
        int dg[NN+3];
        int od[NN+1];
        int lz, sh, e;
        bit stk, special;
        for (int k = 0; k < NN + 3; k++) dg[k] = int'(x.sig[(NN+2-k)*4 +: 4]);
        eo = '0;
        eo.nan = x.nan; eo.qnan = x.qnan; eo.snan = x.snan;
        eo.infinity = x.infinity; eo.sign = x.sign;
        e = int'(x.exp);
        stk = (dg[NN+2] != 0);
        special = x.nan || x.infinity;
        lat = 1;
        if (special) begin
            for (int k = 0; k <= NN; k++) od[k] = dg[1+k];
        end else if (dg[0] != 0) begin
            for (int k = 0; k <= NN; k++) od[k] = dg[k];
            stk = stk || (dg[NN+1] != 0);
            e = (e + 1) % 4096;
            lat = 2;
            if (e == 'hBFF) begin
                eo.infinity = 1'b1;
                special = 1'b1;
                for (int k = 0; k <= NN; k++) od[k] = 0;
            end
        end else begin
            lz = 0;
            while (lz < NN + 1 && dg[1+lz] == 0) lz++;
            sh = (lz == NN + 1) ? 0 : ((lz < e) ? lz : e);
            for (int k = 0; k <= NN; k++) od[k] = (1 + k + sh <= NN + 1) ? dg[1+k+sh] : 0;
            e = e - sh;
`ifdef DFPNORM_FAST_LZ_EN
            lat = 1 + ((sh > 0) ? 1 : 0);
`else
            lat = 1 + sh;
`endif
        end
        if (!special && stk) begin
            if (od[NN] == 0) od[NN] = 1;
            else if (od[NN] == 5) od[NN] = 6;
        end
        eo.exp = 12'(e);
        for (int k = 0; k <= NN; k++) eo.sig[(NN-k)*4 +: 4] = 4'(od[k]);
    endtask

    // Build a value: overflow digit, nz leading zeros, then lead, zeros, round, sticky.
    function automatic DFP96UNX mk(input int ovf, input int nz, input int lead,
                                   input int rd, input int st, input logic [11:0] e);
        DFP96UNX x;
        x = '0;
        x.exp = e;
        x.sig[(NN+2)*4 +: 4] = 4'(ovf);
        if (nz + 1 <= int'(NN)) x.sig[(NN+1-nz)*4 +: 4] = 4'(lead);
        x.sig[7:4] = 4'(rd);
        x.sig[3:0] = 4'(st);
        return x;
    endfunction

    function automatic DFP96UNX rand_in();
        DFP96UNX x;
        int sel, nz;
        x = '0;
        x.sign = 1'($urandom_range(1));
        sel = $urandom_range(9);
        if (sel < 3)      x.exp = 12'($urandom_range(6));
        else if (sel < 5) x.exp = 12'hBF0 + 12'($urandom_range(14));
        else              x.exp = 12'h200 + 12'($urandom_range(511));
        for (int k = 0; k < int'(NN) + 3; k++) x.sig[(NN+2-k)*4 +: 4] = 4'($urandom_range(9));
        if ($urandom_range(3) != 0) begin
            x.sig[(NN+2)*4 +: 4] = 4'd0;
            nz = $urandom_range(NN + 1);
            for (int k = 1; k <= nz; k++) x.sig[(NN+2-k)*4 +: 4] = 4'd0;
        end
        if ($urandom_range(3) == 0) x.sig[7:4] = ($urandom_range(1) != 0) ? 4'd5 : 4'd0;
        sel = $urandom_range(19);
        if (sel == 0) begin
            x.nan  = 1'b1;
            x.qnan = 1'($urandom_range(1));
            x.snan = ~x.qnan;
        end else if (sel == 1) begin
            x.infinity = 1'b1;
        end
        return x;
    endfunction

    // One load-to-done transaction; optional ce stalls and a stray ld while busy.
    task automatic run_op(input DFP96UNX x, input string tag, input bit rnd_ce, input bit poke);
        DFP96UN eo, held;
        int lat, k;
        bit seen, extra;
        model(x, eo, lat);
        @(negedge clk);
        ce = 1'b1; ld = 1'b1; din = x;
        @(posedge clk);
        @(negedge clk);
        check({tag, " busy"}, 160'(busy), 160'(1'b1));
        ld = poke;
        if (poke) din = ~x;
        k = 0; seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            bit ce_now;
            ce_now = ce;
            @(posedge clk);
            if (ce_now) k++;
            @(negedge clk);
            ld = 1'b0;
            if (done) seen = 1'b1;
            else if (rnd_ce) ce = ($urandom_range(3) != 0);
        end
        check({tag, " done"}, 160'(seen), 160'(1'b1));
        check({tag, " latency"}, 160'(k), 160'(lat));
        check({tag, " o"}, 160'(o), 160'(eo));
        check({tag, " idle"}, 160'(busy), 160'(1'b0));
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " pulse"}, 160'(done), 160'(1'b0));
        if (poke) begin
            held = o; extra = 1'b0;
            repeat (8) begin
                @(posedge clk);
                @(negedge clk);
                if (done || busy) extra = 1'b1;
            end
            check({tag, " stray ld"}, 160'(extra), 160'(1'b0));
            check({tag, " hold"}, 160'(o), 160'(held));
        end
    endtask

    initial begin
        DFP96UNX x;
        bit any_done;
        rst = 1'b1; ce = 1'b0; ld = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset o", 160'(o), 160'(0));
        check("reset done", 160'(done), 160'(1'b0));
        check("reset busy", 160'(busy), 160'(1'b0));
        rst = 1'b0;

        // Overflow: one right shift.
        x = mk(1, 0, 0, 0, 0, 12'h300);
        run_op(x, "ovf", 1'b0, 1'b0);
        check("ovf exp", 160'(o.exp), 160'(12'h301));
        check("ovf msd", 160'(o.sig[(NN+1)*4-1 -: 4]), 160'(4'd1));

        // Left shift by three digits.
        x = mk(0, 3, 7, 0, 0, 12'h300);
        run_op(x, "lsh", 1'b0, 1'b0);
        check("lsh exp", 160'(o.exp), 160'(12'h2FD));
        check("lsh msd", 160'(o.sig[(NN+1)*4-1 -: 4]), 160'(4'd7));

        // Denormal: exponent runs out first.
        x = mk(0, 5, 8, 0, 0, 12'h002);
        run_op(x, "denorm", 1'b0, 1'b0);
        check("denorm exp", 160'(o.exp), 160'(12'h000));
        check("denorm lz", 160'(o.sig[(NN+1)*4-1 -: 16]), 160'(16'h0008));

        // Sticky fold.
        x = mk(0, 0, 9, 5, 3, 12'h300);
        run_op(x, "fold56", 1'b0, 1'b0);
        check("fold56 rd", 160'(o.sig[3:0]), 160'(4'd6));
        x = mk(0, 0, 9, 0, 0, 12'h300);
        run_op(x, "fold00", 1'b0, 1'b0);
        check("fold00 rd", 160'(o.sig[3:0]), 160'(4'd0));

        // Overflow into infinity.
        x = mk(1, 0, 0, 4, 2, 12'hBFE);
        run_op(x, "toinf", 1'b0, 1'b0);
        check("toinf flag", 160'(o.infinity), 160'(1'b1));
        check("toinf sig", 160'(o.sig), 160'(0));
        check("toinf exp", 160'(o.exp), 160'(12'hBFF));

        // Zero significand keeps exponent and sign.
        x = mk(0, 0, 0, 0, 0, 12'h123);
        x.sign = 1'b1;
        run_op(x, "zero", 1'b0, 1'b0);

        // NaN passes straight through.
        x = mk(0, 2, 4, 1, 2, 12'h300);
        x.nan = 1'b1; x.qnan = 1'b1;
        run_op(x, "nan", 1'b0, 1'b0);
        check("nan flags", 160'({o.nan, o.qnan, o.snan, o.infinity}), 160'(4'b1100));

        // ld while busy is ignored.
        x = mk(0, 3, 7, 0, 0, 12'h300);
        run_op(x, "poke", 1'b0, 1'b1);

        // Reset during LSHIFT abandons the operation.
        @(negedge clk);
        ce = 1'b1; ld = 1'b1; din = mk(0, 10, 3, 0, 0, 12'h300);
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst busy", 160'(busy), 160'(1'b0));
        check("rst o", 160'(o), 160'(0));
        rst = 1'b0;
        any_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("rst nodone", 160'(any_done), 160'(1'b0));

        // Randomised traffic with ce stalls.
        for (int n = 0; n < 300; n++) begin
            x = rand_in();
            run_op(x, "rand", 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
